// File: rtl/apb_slave_pkg.sv
// Shared types and address-map helpers for the APB register file.
package apb_slave_pkg;

  // Transfer FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } apb_state_e;

  // Wait-state counter width (WAIT_STATES is at most 15)
  localparam int CNT_W = 4;

  // Index of the read-only status register for a given register count
  function automatic int ro_index(input int num_regs);
    return num_regs - 1;
  endfunction

  // First byte address past the register window
  function automatic int addr_limit(input int num_regs);
    return num_regs * 4;
  endfunction

  localparam int DEF_NUM_REGS   = 8;
  localparam int DEF_RO_IDX     = ro_index(DEF_NUM_REGS);
  localparam int DEF_ADDR_LIMIT = addr_limit(DEF_NUM_REGS);

endpackage

// File: rtl/apb_slave_regbank.sv
// Register bank: RW registers, write decode with per-register strobe,
// and the combinational read mux (top of the map returns i_status).
module apb_slave_regbank
  import apb_slave_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8,
  parameter int IDX_W      = $clog2(NUM_REGS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_wr_en,
  input  logic [IDX_W-1:0]                 i_wr_idx,
  input  logic [DATA_WIDTH-1:0]            i_wr_data,
  input  logic [IDX_W-1:0]                 i_rd_idx,
  input  logic [DATA_WIDTH-1:0]            i_status,
  output logic [DATA_WIDTH-1:0]            o_rd_data,
  output logic [(NUM_REGS-1)*DATA_WIDTH-1:0] o_regs,
  output logic [NUM_REGS-2:0]              o_wr_pulse
);

  localparam int NUM_RW = NUM_REGS - 1;
  localparam int RO_IDX = ro_index(NUM_REGS);

  logic [DATA_WIDTH-1:0] regs_q [NUM_RW];
  logic [DATA_WIDTH-1:0] regs_d [NUM_RW];
  logic [NUM_RW-1:0]     wr_pulse_q;
  logic [NUM_RW-1:0]     wr_pulse_d;
  logic [DATA_WIDTH-1:0] rd_data;

  // Write decode: only the addressed RW register loads, and its strobe fires
  always_comb begin
    wr_pulse_d = '0;
    for (int k = 0; k < NUM_RW; k++) begin
      regs_d[k] = regs_q[k];
      if (i_wr_en && (i_wr_idx == IDX_W'(k))) begin
        regs_d[k]     = i_wr_data;
        wr_pulse_d[k] = 1'b1;
      end
    end
  end

  // Register storage and strobe flops, cleared by the async reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_RW; k++) begin
        regs_q[k] <= '0;
      end
      wr_pulse_q <= '0;
    end else begin
      for (int k = 0; k < NUM_RW; k++) begin
        regs_q[k] <= regs_d[k];
      end
      wr_pulse_q <= wr_pulse_d;
    end
  end

  // Read mux: RW registers by index, status word at the top index
  always_comb begin
    rd_data = '0;
    if (i_rd_idx == IDX_W'(RO_IDX)) begin
      rd_data = i_status;
    end else begin
      for (int k = 0; k < NUM_RW; k++) begin
        if (i_rd_idx == IDX_W'(k)) begin
          rd_data = regs_q[k];
        end
      end
    end
  end

  assign o_rd_data  = rd_data;
  assign o_wr_pulse = wr_pulse_q;

  generate
    for (genvar gi = 0; gi < NUM_RW; gi++) begin : g_regs_out
      assign o_regs[gi*DATA_WIDTH +: DATA_WIDTH] = regs_q[gi];
    end
  endgenerate

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer with a small register file: configurable wait states,
// error response on bad addresses and on writes to the status register.
module apb_slave_regfile
  import apb_slave_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic                               i_PCLK,
  input  logic                               i_PRESETn,
  input  logic [ADDR_WIDTH-1:0]              i_PADDR,
  input  logic                               i_PSEL,
  input  logic                               i_PENABLE,
  input  logic                               i_PWRITE,
  input  logic [DATA_WIDTH-1:0]              i_PWDATA,
  output logic                               o_PREADY,
  output logic [DATA_WIDTH-1:0]              o_PRDATA,
  output logic                               o_PSLVERR,
  input  logic [DATA_WIDTH-1:0]              i_status,
  output logic [(NUM_REGS-1)*DATA_WIDTH-1:0] o_regs,
  output logic [NUM_REGS-2:0]                o_wr_pulse
);

  localparam int IDX_W      = $clog2(NUM_REGS);
  localparam int RO_IDX     = ro_index(NUM_REGS);
  localparam int ADDR_LIMIT = addr_limit(NUM_REGS);
  localparam logic [CNT_W-1:0] WS_LOAD = CNT_W'(WAIT_STATES);

  apb_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  pready_q, pready_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  pslverr_q, pslverr_d;

  logic                  enter_done;
  logic                  wr_en;
  logic                  addr_valid;
  logic                  is_ro;
  logic                  wr_ok;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] rd_data;

  assign idx        = i_PADDR[2 +: IDX_W];
  assign addr_valid = (i_PADDR < ADDR_WIDTH'(ADDR_LIMIT)) && (i_PADDR[1:0] == 2'b00);
  assign is_ro      = (idx == IDX_W'(RO_IDX));
  assign wr_ok      = i_PWRITE && addr_valid && !is_ro;

  apb_slave_regbank #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W)
  ) u_regbank (
    .clk        (i_PCLK),
    .rst_n      (i_PRESETn),
    .i_wr_en    (wr_en),
    .i_wr_idx   (idx),
    .i_wr_data  (i_PWDATA),
    .i_rd_idx   (idx),
    .i_status   (i_status),
    .o_rd_data  (rd_data),
    .o_regs     (o_regs),
    .o_wr_pulse (o_wr_pulse)
  );

  // Next-state, wait counting and response generation; response fields are
  // only non-zero for the single cycle that PREADY is high
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pready_d   = 1'b0;
    prdata_d   = '0;
    pslverr_d  = 1'b0;
    wr_en      = 1'b0;
    enter_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Only a proper setup phase starts a transfer; a stray PENABLE is ignored
        if (i_PSEL && !i_PENABLE) begin
          cnt_d = WS_LOAD;
          if (WAIT_STATES == 0) begin
            enter_done = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!i_PSEL) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (i_PENABLE) begin
          if (cnt_q <= CNT_W'(1)) begin
            enter_done = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        // Write lands at the edge closing the PREADY cycle, unless the
        // requester dropped PSEL during it
        state_d = ST_IDLE;
        cnt_d   = '0;
        wr_en   = i_PSEL && i_PENABLE && wr_ok;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (enter_done) begin
      state_d   = ST_DONE;
      cnt_d     = '0;
      pready_d  = 1'b1;
      pslverr_d = !addr_valid || (i_PWRITE && is_ro);
      if (!i_PWRITE && addr_valid) begin
        prdata_d = rd_data;
      end
    end
  end

  // State, counter and registered APB response
  always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
    if (!i_PRESETn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
    end
  end

  assign o_PREADY  = pready_q;
  assign o_PRDATA  = prdata_q;
  assign o_PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: two instances (0 and 1 wait states) driven
// by transaction tasks; a transaction-level model predicts every output
// each cycle and a single negedge process compares.
module tb_apb_slave_regfile;

  logic        clk;
  logic        rst_n   [2];
  logic        psel    [2];
  logic        penable [2];
  logic        pwrite  [2];
  logic [31:0] paddr   [2];
  logic [31:0] pwdata  [2];
  logic [31:0] status  [2];
  logic        pready  [2];
  logic [31:0] prdata  [2];
  logic        pslverr [2];
  logic [223:0] regs_o [2];
  logic [6:0]  pulse   [2];

  // Model state
  int          ws [2];
  logic [31:0] mregs [2][7];
  bit          pend_valid [2];
  int          pend_idx   [2];
  logic [31:0] pend_data  [2];
  logic        exp_pready  [2];
  logic [31:0] exp_prdata  [2];
  logic        exp_pslverr [2];
  logic [6:0]  exp_pulse   [2];

  int n_checks = 0;
  int n_pass   = 0;
  bit check_en = 0;

  apb_slave_regfile #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(8), .WAIT_STATES(0)) dut0 (
    .i_PCLK(clk), .i_PRESETn(rst_n[0]), .i_PADDR(paddr[0]), .i_PSEL(psel[0]),
    .i_PENABLE(penable[0]), .i_PWRITE(pwrite[0]), .i_PWDATA(pwdata[0]),
    .o_PREADY(pready[0]), .o_PRDATA(prdata[0]), .o_PSLVERR(pslverr[0]),
    .i_status(status[0]), .o_regs(regs_o[0]), .o_wr_pulse(pulse[0])
  );

  apb_slave_regfile #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(8), .WAIT_STATES(1)) dut1 (
    .i_PCLK(clk), .i_PRESETn(rst_n[1]), .i_PADDR(paddr[1]), .i_PSEL(psel[1]),
    .i_PENABLE(penable[1]), .i_PWRITE(pwrite[1]), .i_PWDATA(pwdata[1]),
    .o_PREADY(pready[1]), .o_PRDATA(prdata[1]), .o_PSLVERR(pslverr[1]),
    .i_status(status[1]), .o_regs(regs_o[1]), .o_wr_pulse(pulse[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit (got timeout, required finish)");
    $fatal(1);
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  function automatic logic [223:0] model_regs(input int u);
    logic [223:0] f;
    f = '0;
    for (int k = 0; k < 7; k++) f[k*32 +: 32] = mregs[u][k];
    return f;
  endfunction

  // Per-cycle comparison of every output of both instances
  always @(negedge clk) begin
    if (check_en) begin
      for (int u = 0; u < 2; u++) begin
        check($sformatf("u%0d_pready", u),  pready[u],  exp_pready[u]);
        check($sformatf("u%0d_prdata", u),  prdata[u],  exp_prdata[u]);
        check($sformatf("u%0d_pslverr", u), pslverr[u], exp_pslverr[u]);
        check($sformatf("u%0d_wr_pulse", u), pulse[u],  exp_pulse[u]);
        check($sformatf("u%0d_regs", u),    regs_o[u],  model_regs(u));
      end
    end
  end

  // Advance one cycle: land last cycle's committed write, default outputs to idle
  task automatic next_cycle();
    @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      if (pend_valid[u]) begin
        mregs[u][pend_idx[u]] = pend_data[u];
        exp_pulse[u] = 7'd1 << pend_idx[u];
      end else begin
        exp_pulse[u] = '0;
      end
      pend_valid[u]  = 0;
      exp_pready[u]  = 1'b0;
      exp_prdata[u]  = '0;
      exp_pslverr[u] = 1'b0;
      psel[u]        = 1'b0;
      penable[u]     = 1'b0;
    end
  endtask

  // One APB transfer; returns at +1 into the PREADY cycle (or the abort cycle)
  task automatic xfer(input int u, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wd, input int abort_at);
    bit valid, err;
    int idx;
    next_cycle();
    psel[u] = 1'b1; penable[u] = 1'b0; pwrite[u] = wr; paddr[u] = addr; pwdata[u] = wd;
    for (int a = 1; a <= ws[u] + 1; a++) begin
      next_cycle();
      if (a == abort_at && a <= ws[u]) return;
      psel[u] = 1'b1; penable[u] = 1'b1;
      if (a == ws[u] + 1) begin
        valid = (addr < 32'd32) && (addr[1:0] == 2'b00);
        idx   = int'(addr[4:2]);
        err   = !valid || (wr && idx == 7);
        exp_pready[u]  = 1'b1;
        exp_pslverr[u] = err;
        exp_prdata[u]  = '0;
        if (!wr && valid) begin
          if (idx == 7) exp_prdata[u] = status[u];
          else          exp_prdata[u] = mregs[u][idx];
        end
        if (a == abort_at) begin
          psel[u] = 1'b0; penable[u] = 1'b0;
        end else if (wr && !err) begin
          pend_valid[u] = 1; pend_idx[u] = idx; pend_data[u] = wd;
        end
      end
    end
  endtask

  // Assert reset mid-cycle, check outputs clear immediately, release next cycle
  task automatic reset_mid(input int u);
    rst_n[u] = 1'b0; psel[u] = 1'b0; penable[u] = 1'b0;
    #1;
    check($sformatf("u%0d_rst_pready", u),  pready[u],  1'b0);
    check($sformatf("u%0d_rst_prdata", u),  prdata[u],  32'd0);
    check($sformatf("u%0d_rst_pslverr", u), pslverr[u], 1'b0);
    check($sformatf("u%0d_rst_regs", u),    regs_o[u],  224'd0);
    check($sformatf("u%0d_rst_pulse", u),   pulse[u],   7'd0);
    for (int k = 0; k < 7; k++) mregs[u][k] = '0;
    pend_valid[u] = 0; exp_pready[u] = 0; exp_prdata[u] = '0; exp_pslverr[u] = 0; exp_pulse[u] = '0;
    next_cycle();
    rst_n[u] = 1'b1;
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 5))
      0, 1, 2: return 32'($urandom_range(0, 7)) * 32'd4;
      3:       return 32'($urandom_range(0, 31));
      4:       return 32'h20 + 32'($urandom_range(0, 8)) * 32'd4;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int gap, abort_at;
    ws[0] = 0; ws[1] = 1;
    for (int u = 0; u < 2; u++) begin
      rst_n[u] = 1'b0; psel[u] = 0; penable[u] = 0; pwrite[u] = 0;
      paddr[u] = '0; pwdata[u] = '0; status[u] = '0;
      for (int k = 0; k < 7; k++) mregs[u][k] = '0;
      pend_valid[u] = 0; pend_idx[u] = 0; pend_data[u] = '0;
      exp_pready[u] = 0; exp_prdata[u] = '0; exp_pslverr[u] = 0; exp_pulse[u] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check_en = 1;
    @(negedge clk);
    #1;
    check("reset_pready_u1", pready[1], 1'b0);
    check("reset_regs_u1", regs_o[1], 224'd0);
    next_cycle();
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;

    // Single wait state: write, read-back, status register, bad addresses
    status[1] = 32'h12345678;
    xfer(1, 1, 32'h04, 32'hDEADBEEF, -1);
    #2;
    check("ws1_wr_pready_2nd", pready[1], 1'b1);
    check("ws1_wr_pslverr", pslverr[1], 1'b0);
    next_cycle(); #2;
    check("ws1_wr_pulse", pulse[1], 7'b0000010);
    check("ws1_reg1", regs_o[1][63:32], 32'hDEADBEEF);
    next_cycle(); #2;
    check("ws1_pulse_gone", pulse[1], 7'b0000000);

    xfer(1, 0, 32'h04, 32'h0, -1);
    #2;
    check("ws1_rd_reg1", prdata[1], 32'hDEADBEEF);
    next_cycle(); #2;
    check("ws1_rd_prdata_after", prdata[1], 32'h0);

    xfer(1, 0, 32'h1C, 32'h0, -1);
    #2;
    check("ws1_rd_status", prdata[1], 32'h12345678);
    xfer(1, 1, 32'h1C, 32'h55, -1);
    #2;
    check("ws1_wr_ro_err", pslverr[1], 1'b1);
    next_cycle(); #2;
    check("ws1_wr_ro_nopulse", pulse[1], 7'd0);

    xfer(1, 0, 32'h20, 32'h0, -1);
    #2;
    check("ws1_rd_20_err", pslverr[1], 1'b1);
    check("ws1_rd_20_data", prdata[1], 32'h0);
    xfer(1, 0, 32'h06, 32'h0, -1);
    #2;
    check("ws1_rd_06_err", pslverr[1], 1'b1);
    xfer(1, 1, 32'h40, 32'hFFFFFFFF, -1);
    #2;
    check("ws1_wr_40_err", pslverr[1], 1'b1);
    next_cycle(); #2;
    check("ws1_regs_unchanged", regs_o[1], 224'hDEADBEEF_00000000);

    // Reset during the wait state of a write: nothing lands
    next_cycle();
    psel[1] = 1; penable[1] = 0; pwrite[1] = 1; paddr[1] = 32'h0C; pwdata[1] = 32'hFF;
    next_cycle();
    psel[1] = 1; penable[1] = 1;
    reset_mid(1);
    next_cycle(); next_cycle(); #2;
    check("ws1_reg3_after_rst", regs_o[1][127:96], 32'h0);
    xfer(1, 0, 32'h0C, 32'h0, -1);
    #2;
    check("ws1_rd_reg3_zero", prdata[1], 32'h0);

    // Reset during the PREADY cycle drops the response at once
    status[1] = 32'hCAFEF00D;
    xfer(1, 0, 32'h1C, 32'h0, -1);
    #2;
    check("ws1_rd_status2", prdata[1], 32'hCAFEF00D);
    reset_mid(1);

    // Zero wait states, back-to-back writes
    xfer(0, 1, 32'h00, 32'h1, -1);
    #2;
    check("ws0_first_ready", pready[0], 1'b1);
    xfer(0, 1, 32'h08, 32'h2, -1);
    #2;
    check("ws0_second_ready", pready[0], 1'b1);
    next_cycle(); #2;
    check("ws0_regs", regs_o[0], 224'h00000002_00000000_00000001);

    // Randomized traffic on each instance
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 150; i++) begin
        gap = $urandom_range(0, 2);
        repeat (gap) next_cycle();
        if ($urandom_range(0, 99) < 5) begin
          next_cycle();
          psel[u] = 1; penable[u] = 1; pwrite[u] = 1;
          paddr[u] = 32'($urandom_range(0, 6)) * 32'd4; pwdata[u] = $urandom;
        end else begin
          status[u] = $urandom;
          abort_at = ($urandom_range(0, 9) == 0) ? $urandom_range(1, ws[u] + 1) : -1;
          xfer(u, bit'($urandom_range(0, 1)), pick_addr(), $urandom, abort_at);
        end
      end
    end

    repeat (3) next_cycle();
    @(negedge clk);
    #1;
    check_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/apb_slave_regfile.md
APB_SLAVE_REGFILE -- requirements
Module: apb_slave_regfile

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, APB data width.
REQ-003 SHALL have parameter NUM_REGS, default 8, register count, power of two, >=2.
REQ-004 SHALL have parameter WAIT_STATES, default 1, range 0..15, access cycles with PREADY low before completion.
REQ-005 SHALL have port i_PCLK, input, 1, the single clock; all logic on rising edge.
REQ-006 SHALL have port i_PRESETn, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have ports i_PADDR input ADDR_WIDTH, i_PSEL input 1, i_PENABLE input 1, i_PWRITE input 1, i_PWDATA input DATA_WIDTH: APB requester signals.
REQ-008 SHALL have ports o_PREADY output 1, o_PRDATA output DATA_WIDTH, o_PSLVERR output 1: APB completer signals, all registered.
REQ-009 SHALL have port i_status, input, DATA_WIDTH, value returned by read-only register NUM_REGS-1.
REQ-010 SHALL have port o_regs, output, (NUM_REGS-1)*DATA_WIDTH, flattened RW register contents, reg k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-011 SHALL have port o_wr_pulse, output, NUM_REGS-1, one-cycle strobe per RW register on committed write.

Function
REQ-012 Address map: word-aligned; index = PADDR[2 +: log2(NUM_REGS)]; regs 0..NUM_REGS-2 RW, reg NUM_REGS-1 RO (i_status).
REQ-013 Address invalid if PADDR >= NUM_REGS*4 or PADDR[1:0] != 0.
REQ-014 FSM states IDLE, WAIT, DONE.
REQ-015 IDLE: on PSEL=1 and PENABLE=0 (setup cycle), load wait counter with WAIT_STATES; go to DONE if WAIT_STATES=0, else WAIT.
REQ-016 WAIT: while PSEL=1 and PENABLE=1, decrement counter; when it reaches 1, go to DONE. Completion = PREADY high in access cycle WAIT_STATES+1.
REQ-017 Entering DONE: o_PREADY<=1; o_PRDATA and o_PSLVERR registered in the same edge, valid in the PREADY cycle.
REQ-018 DONE: at the edge ending the PREADY cycle, commit write if allowed; o_PREADY<=0, o_PSLVERR<=0; go to IDLE.
REQ-019 Read, valid address: o_PRDATA = register value (reg NUM_REGS-1 returns i_status sampled at DONE entry); o_PSLVERR=0.
REQ-020 Invalid address, read or write: o_PSLVERR=1, o_PRDATA=0, no state change.
REQ-021 Write to RO register: o_PSLVERR=1, no state change, no strobe.
REQ-022 Committed write: reg updated with i_PWDATA; o_wr_pulse[idx]=1 for exactly the following cycle.
REQ-023 o_PRDATA SHALL be 0 outside the PREADY cycle, including writes.
REQ-024 Abort: PSEL=0 while in WAIT or DONE -> IDLE next edge; PREADY/PSLVERR 0; no write, no strobe.
REQ-025 Back-to-back: setup cycle immediately after the PREADY cycle SHALL be accepted from IDLE with no extra gap.
REQ-026 PENABLE=1 seen in IDLE without prior setup SHALL be ignored.

Reset
REQ-027 On i_PRESETn=0, immediately: state IDLE, counter 0, o_PREADY 0, o_PRDATA 0, o_PSLVERR 0, all RW regs 0, o_wr_pulse 0.
REQ-028 Reset mid-transfer SHALL discard the transfer; no write lands.

Structure
REQ-029 Package apb_slave_pkg SHALL hold the FSM state enum and localparams for the RO index and address-valid limit.
REQ-030 Sub-module apb_slave_regbank SHALL hold RW registers, write decode and read mux; FSM and wait counter stay at top.

Verification
REQ-031 WAIT_STATES=1: write 0xDEADBEEF to 0x04 -> PREADY high 2nd access cycle, PSLVERR 0, o_regs reg1=0xDEADBEEF, o_wr_pulse=0000010 for one cycle.
REQ-032 Read 0x04 after REQ-031 -> o_PRDATA=0xDEADBEEF in PREADY cycle, 0 otherwise.
REQ-033 i_status=0x12345678, read 0x1C -> PRDATA 0x12345678; write 0x1C -> PSLVERR 1, no strobe.
REQ-034 Read 0x20 and 0x06 -> PSLVERR 1, PRDATA 0; write 0x40 -> regs unchanged.
REQ-035 WAIT_STATES=0 back-to-back writes 0x00=1, 0x08=2 -> each PREADY in first access cycle, both regs updated.
REQ-036 Reset asserted during WAIT of write 0x0C=0xFF -> outputs 0 immediately; reg3 stays 0 after release.
